// File: rtl/aes_round_ctrl_if.sv
// aes_round_ctrl_if: the handshake and datapath-control signals of the AES round sequencer.
//   slave  : the sequencer. It takes in_valid, rk_valid and out_ready. It drives
//            in_ready, key requests, datapath selects, round, busy and out_valid.
//   master : the environment, meaning the block source, the key schedule and the consumer.
interface aes_round_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic       rk_req;
  logic [3:0] rk_idx;
  logic       rk_valid;
  logic       state_load;
  logic       sel_input;
  logic       bypass_mix;
  logic [3:0] round;
  logic       busy;
  logic       out_valid;
  logic       out_ready;

  modport slave (
    input  in_valid, rk_valid, out_ready,
    output in_ready, rk_req, rk_idx, state_load, sel_input, bypass_mix,
           round, busy, out_valid
  );

  modport master (
    output in_valid, rk_valid, out_ready,
    input  in_ready, rk_req, rk_idx, state_load, sel_input, bypass_mix,
           round, busy, out_valid
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES round sequencer for a single-round datapath.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; aborts any block in flight
//   bus   : aes_round_ctrl_if.slave. It carries the block handshake (in_valid/in_ready),
//           the round-key fetch (rk_req/rk_idx/rk_valid), the datapath controls
//           (state_load/sel_input/bypass_mix), the status signals (round/busy) and
//           the result handshake (out_valid/out_ready).
// Flow: IDLE -> KEY0, where the initial addroundkey loads plaintext^key0.
// Next is ROUND 1..NROUNDS, with one state load per delivered key.
// The last round bypasses mixcolumns. DONE follows and holds the result.
module aes_round_ctrl #(
  parameter int NROUNDS = 10
) (
  input  logic              clk,
  input  logic              reset,
  aes_round_ctrl_if.slave   bus
);

  localparam logic [3:0] NR = 4'(NROUNDS);

  typedef enum logic [1:0] {IDLE, KEY0, ROUND, DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] round_q, round_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      round_q <= 4'd0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  logic req;

  // Only state_load looks at rk_valid in the same cycle. Every other output
  // decodes from the registered state/round, so the outputs cannot glitch on input activity.
  always_comb begin
    state_d        = state_q;
    round_d        = round_q;
    req            = 1'b0;
    bus.in_ready   = 1'b0;
    bus.sel_input  = 1'b0;
    bus.bypass_mix = 1'b0;
    bus.out_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          state_d = KEY0;
          round_d = 4'd0;
        end
      end
      KEY0: begin
        req           = 1'b1;
        bus.sel_input = 1'b1;
        if (bus.rk_valid) begin
          state_d = ROUND;
          round_d = 4'd1;
        end
      end
      ROUND: begin
        req            = 1'b1;
        bus.bypass_mix = (round_q == NR);
        // round stays at NROUNDS through DONE, so the 4-bit counter never wraps
        if (bus.rk_valid) begin
          if (round_q == NR) state_d = DONE;
          else               round_d = round_q + 4'd1;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
          round_d = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        round_d = 4'd0;
      end
    endcase
  end

  assign bus.rk_req     = req;
  // rk_idx equals round while a key is requested: 0 in KEY0, and r in ROUND r.
  assign bus.rk_idx     = req ? round_q : 4'd0;
  assign bus.state_load = req & bus.rk_valid;
  assign bus.round      = round_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_aes_round_ctrl.sv
module tb_aes_round_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0, rk_valid = 1'b0, out_ready = 1'b0;
  int   errors = 0, checks = 0;

  always #5 clk = ~clk;

  aes_round_ctrl_if if10 ();
  aes_round_ctrl_if if14 ();

  assign if10.in_valid  = in_valid;
  assign if10.rk_valid  = rk_valid;
  assign if10.out_ready = out_ready;
  assign if14.in_valid  = in_valid;
  assign if14.rk_valid  = rk_valid;
  assign if14.out_ready = out_ready;

  aes_round_ctrl #(.NROUNDS(10)) dut10 (.clk(clk), .reset(reset), .bus(if10.slave));
  aes_round_ctrl #(.NROUNDS(14)) dut14 (.clk(clk), .reset(reset), .bus(if14.slave));

  // Observation vector fields, from the MSB down:
  // in_ready, busy, rk_req, rk_idx[3:0], state_load, sel_input, bypass_mix, round[3:0], out_valid
  logic [14:0] o10, o14;
  assign o10 = {if10.in_ready, if10.busy, if10.rk_req, if10.rk_idx, if10.state_load,
                if10.sel_input, if10.bypass_mix, if10.round, if10.out_valid};
  assign o14 = {if14.in_ready, if14.busy, if14.rk_req, if14.rk_idx, if14.state_load,
                if14.sel_input, if14.bypass_mix, if14.round, if14.out_valid};

  int          waits[16];
  logic [14:0] exp_q[$];
  logic [2:0]  stim_q[$];   // {in_valid, rk_valid, out_ready} per cycle

  function automatic logic [14:0] pk(bit ir, bit bz, bit rq, int idx, bit ld, bit sel,
                                     bit byp, int rnd, bit ov);
    return {ir, bz, rq, 4'(idx), ld, sel, byp, 4'(rnd), ov};
  endfunction

  // Reference model: builds the expected cycle-by-cycle trace of one block.
  // The block is described by its per-key stall counts (waits) and by the number
  // of cycles the consumer refuses the result (odly).
  // Cycle 0 is the accepting IDLE cycle.
  task automatic build(int n, int odly, bit ivh);
    bit iv;
    exp_q.delete(); stim_q.delete();
    stim_q.push_back({1'b1, 1'($urandom), 1'($urandom)});
    exp_q.push_back(pk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k <= n; k++) begin
      for (int w = 0; w < waits[k]; w++) begin
        iv = ivh ? 1'b1 : 1'($urandom);
        stim_q.push_back({iv, 1'b0, 1'($urandom)});
        exp_q.push_back(pk(0, 1, 1, k, 0, k == 0, k == n, k, 0));
      end
      iv = ivh ? 1'b1 : 1'($urandom);
      stim_q.push_back({iv, 1'b1, 1'($urandom)});
      exp_q.push_back(pk(0, 1, 1, k, 1, k == 0, k == n, k, 0));
    end
    for (int d = 0; d < odly; d++) begin
      iv = ivh ? 1'b1 : 1'($urandom);
      stim_q.push_back({iv, 1'($urandom), 1'b0});
      exp_q.push_back(pk(0, 1, 0, 0, 0, 0, 0, n, 1));
    end
    iv = ivh ? 1'b1 : 1'($urandom);
    stim_q.push_back({iv, 1'($urandom), 1'b1});
    exp_q.push_back(pk(0, 1, 0, 0, 0, 0, 0, n, 1));
    if (!ivh) begin
      stim_q.push_back({1'b0, 1'($urandom), 1'($urandom)});
      exp_q.push_back(pk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic run_trace(bit big, int n, int stop_at, string tag);
    logic [14:0] obs;
    int loads = 0;
    for (int c = 0; c < exp_q.size(); c++) begin
      if (stop_at >= 0 && c >= stop_at) break;
      @(negedge clk);
      {in_valid, rk_valid, out_ready} = stim_q[c];
      #1;
      obs = big ? o14 : o10;
      loads += int'(obs[7]);
      checks++;
      if (obs !== exp_q[c]) begin
        errors++;
        $display("FAIL %s cyc%0d trace got=%h exp=%h", tag, c, obs, exp_q[c]);
      end
    end
    if (stop_at < 0) begin
      checks++;
      if (loads !== n + 1) begin
        errors++;
        $display("FAIL %s load_count got=%0d exp=%0d", tag, loads, n + 1);
      end
    end
  endtask

  task automatic clear_waits();
    for (int i = 0; i < 16; i++) waits[i] = 0;
  endtask

  task automatic test_reset();
    checks++;
    if (o10 !== pk(1, 0, 0, 0, 0, 0, 0, 0, 0)) begin
      errors++; $display("FAIL reset10 got=%h exp=%h", o10, pk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    checks++;
    if (o14 !== pk(1, 0, 0, 0, 0, 0, 0, 0, 0)) begin
      errors++; $display("FAIL reset14 got=%h exp=%h", o14, pk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_single();
    clear_waits(); build(10, 0, 0); run_trace(0, 10, -1, "single");
  endtask

  task automatic test_stall();
    clear_waits(); waits[0] = 3; waits[5] = 2;
    build(10, 0, 0); run_trace(0, 10, -1, "stall");
  endtask

  task automatic test_out_hold();
    clear_waits(); build(10, 4, 0); run_trace(0, 10, -1, "out_hold");
  endtask

  task automatic test_back_to_back();
    clear_waits(); build(10, 0, 1); run_trace(0, 10, -1, "b2b_first");
    build(10, 1, 0); run_trace(0, 10, -1, "b2b_second");
  endtask

  task automatic test_random();
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < 16; i++) waits[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      build(10, $urandom_range(0, 3), 0);
      run_trace(0, 10, -1, $sformatf("random%0d", b));
    end
  endtask

  task automatic test_reset_mid();
    clear_waits(); build(10, 0, 0);
    run_trace(0, 10, 6, "reset_mid");   // cycles 0..5, block is in ROUND 5
    @(negedge clk);
    rk_valid = 1'b1; in_valid = 1'b1;
    reset = 1'b1;
    #1;
    checks++;
    if ({if10.busy, if10.in_ready, if10.rk_req, if10.state_load} !== 4'b0100) begin
      errors++;
      $display("FAIL reset_mid busy/in_ready/rk_req/load got=%b exp=0100",
               {if10.busy, if10.in_ready, if10.rk_req, if10.state_load});
    end
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (o10 !== pk(1, 0, 0, 0, 0, 0, 0, 0, 0)) begin
      errors++; $display("FAIL reset_mid_idle got=%h exp=%h", o10, pk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    waits[3] = 1;
    build(10, 2, 0); run_trace(0, 10, -1, "after_reset");
  endtask

  task automatic test_nrounds14();
    // Resynchronise the N=14 instance, which saw unrelated stimulus until now
    @(negedge clk); reset = 1'b1; in_valid = 1'b0;
    @(negedge clk); reset = 1'b0;
    clear_waits(); build(14, 0, 0); run_trace(1, 14, -1, "n14");
    waits[14] = 2; waits[0] = 1;
    build(14, 1, 0); run_trace(1, 14, -1, "n14_stall");
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    test_reset();
    @(negedge clk); reset = 1'b0;
    test_single();
    test_stall();
    test_out_hold();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_nrounds14();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
